recipe_checker: RTL and testbench
=================================

// Module: recipe_checker
// PURPOSE
//  Reader/consumer of the synchronous cake ROM (3-bit address, 7-bit one-hot ingredient, 1-cycle read latency).
//  Walks the recipe steps in order, fetching each expected ingredient from the ROM.
//  Compares every player move (7-bit one-hot) against the expected ingredient.
//  Reports recipe complete (acertou) or first mistake/timeout (errou); sits between player input and game FSM.
// PARAMETERS
//  N_STEPS         8    recipe length; steps 0..N_STEPS-1, must be <= 2**ADDR_W
//  ADDR_W          3    ROM address width
//  DATA_W          7    ROM data / move width
//  TIMEOUT_CYCLES  1000 max cycles in WAIT_PLAY per step (used only with RECIPE_TIMEOUT_EN)
// PORTS
//  clock          in   1       system clock, all logic on rising edge
//  reset          in   1       synchronous, active-high
//  iniciar        in   1       start/restart; sampled only in IDLE, DONE_OK, DONE_ERR
//  jogada         in   DATA_W  player move, one-hot ingredient
//  jogada_valida  in   1       1-cycle strobe qualifying jogada
//  rom_address    out  ADDR_W  ROM address (= step register)
//  rom_data       in   DATA_W  ROM data_out, valid 1 cycle after address sampled
//  etapa          out  ADDR_W  current step index
//  pronto         out  1       high in DONE_OK/DONE_ERR
//  acertou        out  1       high in DONE_OK
//  errou          out  1       high in DONE_ERR
//  timeout        out  1       high in DONE_ERR when the cause was timeout
//  db_estado      out  3       state encoding, debug
// BEHAVIOUR
//  Reset: state=IDLE; step=0; expected=0; timer=0; all flags 0; rom_address=0; etapa=0.
//  rom_address and etapa are driven from the step register.
//  States: IDLE=0, FETCH=1, LATCH=2, WAIT_PLAY=3, DONE_OK=4, DONE_ERR=5.
//  IDLE: iniciar=1 -> FETCH with step=0.
//  FETCH: ROM samples rom_address at this edge -> LATCH.
//  LATCH: expected<=rom_data; timer<=0 -> WAIT_PLAY.
//  WAIT_PLAY, jogada_valida=1:
//   - jogada==expected and step==N_STEPS-1 -> DONE_OK.
//   - jogada==expected otherwise -> step<=step+1, FETCH.
//   - any mismatch, incl. zero or multi-hot jogada -> DONE_ERR, timeout=0.
//  DONE_OK/DONE_ERR: flags held; iniciar=1 -> clear flags, step=0, FETCH.
//  Latency: iniciar sampled at edge k -> WAIT_PLAY at edge k+3.
//  Latency: correct non-final move at edge k -> next WAIT_PLAY at edge k+3.
//  Latency: final/wrong move at edge k -> pronto high after edge k+1.
//  Ignored: jogada_valida outside WAIT_PLAY (no queuing); iniciar in FETCH/LATCH/WAIT_PLAY.
//  iniciar and jogada_valida same cycle in DONE_*: iniciar wins.
//  step never wraps: max N_STEPS-1; restart is the only way back to 0.
//  reset asserted in any state, mid-recipe included: reset values on the next edge.
// CONFIGURATION
//  RECIPE_TIMEOUT_EN defined:
//   - timer increments every WAIT_PLAY cycle without jogada_valida.
//   - timer==TIMEOUT_CYCLES-1 without strobe -> DONE_ERR with timeout=1.
//   - strobe on that same cycle takes priority over the timeout.
//  RECIPE_TIMEOUT_EN undefined: no timer logic; WAIT_PLAY waits forever; timeout tied 0.
// TESTING (bench models the ROM: address 0..7 -> 01,02,04,08,10,20,01,02 hex)
//  1 reset, iniciar pulse -> db_estado 1,2,3 on following edges; rom_address=0; expected=7'h01.
//  2 full recipe: 8 correct moves -> etapa steps 0..7; acertou=1, pronto=1 after 8th move; errou=0.
//  3 step 2 move 7'h08 (expected 7'h04) -> DONE_ERR, errou=1, timeout=0, etapa=2.
//  4 moves 7'h00 and 7'h03 at step 0 -> each gives DONE_ERR; strobes in FETCH/LATCH/DONE ignored.
//  5 in DONE_OK: iniciar+jogada_valida together -> FETCH, step=0, flags cleared.
//  6 with RECIPE_TIMEOUT_EN, TIMEOUT_CYCLES=10, no move -> timeout=errou=1 on the 10th WAIT_PLAY cycle.
//  7 reset during WAIT_PLAY at step 4 -> IDLE, etapa=0, all flags 0.

Source files
------------

// File: rtl/recipe_checker.sv
// rtl/recipe_checker.sv - walks the cake recipe ROM and checks player moves; optional timeout via RECIPE_TIMEOUT_EN
module recipe_checker #(
  parameter int N_STEPS        = 8,
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 7,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [DATA_W-1:0] jogada,
  input  logic              jogada_valida,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] etapa,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic [2:0]        db_estado
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LATCH     = 3'd2,
    WAIT_PLAY = 3'd3,
    DONE_OK   = 3'd4,
    DONE_ERR  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(N_STEPS - 1);

  state_t            state;
  logic [ADDR_W-1:0] step;
  logic [DATA_W-1:0] expected;

`ifdef RECIPE_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] timer;
  logic               timeout_r;
  assign timeout = timeout_r;
`else
  // Without the timer the cause of an error is always a wrong move.
  assign timeout = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

  assign rom_address = step;
  assign etapa       = step;
  assign db_estado   = state;

  // Recipe sequencer: fetch expected ingredient, wait for a move, judge it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      step     <= '0;
      expected <= '0;
      pronto   <= 1'b0;
      acertou  <= 1'b0;
      errou    <= 1'b0;
`ifdef RECIPE_TIMEOUT_EN
      timer     <= '0;
      timeout_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE_OK, DONE_ERR: begin
          // Restart takes priority over any strobe seen while finished.
          if (iniciar) begin
            state   <= FETCH;
            step    <= '0;
            pronto  <= 1'b0;
            acertou <= 1'b0;
            errou   <= 1'b0;
`ifdef RECIPE_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          expected <= rom_data;
`ifdef RECIPE_TIMEOUT_EN
          timer <= '0;
`endif
          state <= WAIT_PLAY;
        end
        WAIT_PLAY: begin
          if (jogada_valida) begin
            if (jogada == expected) begin
              if (step == LAST_STEP) begin
                state   <= DONE_OK;
                pronto  <= 1'b1;
                acertou <= 1'b1;
              end else begin
                step  <= step + 1'b1;
                state <= FETCH;
              end
            end else begin
              state  <= DONE_ERR;
              pronto <= 1'b1;
              errou  <= 1'b1;
            end
`ifdef RECIPE_TIMEOUT_EN
          end else if (timer == TIMER_LAST) begin
            state     <= DONE_ERR;
            pronto    <= 1'b1;
            errou     <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recipe_checker.sv
// tb/tb_recipe_checker.sv - directed self-checking bench for recipe_checker
module tb_recipe_checker;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada_valida;
  logic [6:0] jogada, rom_data;
  logic [2:0] rom_address, etapa, db_estado;
  logic       pronto, acertou, errou, timeout;
  int         n_cmp = 0;
  int         n_bad = 0;

  recipe_checker #(.N_STEPS(8), .ADDR_W(3), .DATA_W(7), .TIMEOUT_CYCLES(10)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .jogada_valida(jogada_valida), .rom_address(rom_address), .rom_data(rom_data),
    .etapa(etapa), .pronto(pronto), .acertou(acertou), .errou(errou),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] rom_val(input logic [2:0] a);
    case (a)
      3'd0: return 7'h01;
      3'd1: return 7'h02;
      3'd2: return 7'h04;
      3'd3: return 7'h08;
      3'd4: return 7'h10;
      3'd5: return 7'h20;
      3'd6: return 7'h01;
      default: return 7'h02;
    endcase
  endfunction

  // synchronous cake ROM model, one cycle read latency
  always @(posedge clock) rom_data <= rom_val(rom_address);

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start;
    iniciar = 1'b1; tick; iniciar = 1'b0; tick; tick;
  endtask

  task automatic play(input logic [6:0] m);
    jogada = m; jogada_valida = 1'b1; tick; jogada_valida = 1'b0; jogada = 7'h00;
  endtask

  task automatic test_reset;
    reset = 1'b1; iniciar = 1'b0; jogada_valida = 1'b0; jogada = 7'h00;
    tick; tick;
    n_cmp++; if (db_estado !== 3'd0) begin n_bad++; $display("FAIL rst_state got %0d exp 0", db_estado); end
    n_cmp++; if ({pronto, acertou, errou, timeout} !== 4'b0) begin n_bad++; $display("FAIL rst_flags got %b exp 0000", {pronto, acertou, errou, timeout}); end
    n_cmp++; if (etapa !== 3'd0 || rom_address !== 3'd0) begin n_bad++; $display("FAIL rst_step got %0d/%0d exp 0/0", etapa, rom_address); end
    reset = 1'b0;
    iniciar = 1'b1; tick; iniciar = 1'b0;
    n_cmp++; if (db_estado !== 3'd1) begin n_bad++; $display("FAIL start_fetch got %0d exp 1", db_estado); end
    tick;
    n_cmp++; if (db_estado !== 3'd2) begin n_bad++; $display("FAIL start_latch got %0d exp 2", db_estado); end
    tick;
    n_cmp++; if (db_estado !== 3'd3) begin n_bad++; $display("FAIL start_wait got %0d exp 3", db_estado); end
    n_cmp++; if (rom_address !== 3'd0) begin n_bad++; $display("FAIL start_addr got %0d exp 0", rom_address); end
  endtask

  task automatic test_full_recipe;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (etapa !== 3'(i) || db_estado !== 3'd3) begin n_bad++; $display("FAIL full_step%0d got etapa %0d state %0d exp %0d/3", i, etapa, db_estado, i); end
      play(rom_val(3'(i)));
      if (i < 7) begin
        n_cmp++; if (db_estado !== 3'd1) begin n_bad++; $display("FAIL full_fetch%0d got %0d exp 1", i, db_estado); end
        tick; tick;
      end
    end
    n_cmp++; if (db_estado !== 3'd4) begin n_bad++; $display("FAIL full_state got %0d exp 4", db_estado); end
    n_cmp++; if ({pronto, acertou, errou} !== 3'b110) begin n_bad++; $display("FAIL full_flags got %b exp 110", {pronto, acertou, errou}); end
    n_cmp++; if (etapa !== 3'd7) begin n_bad++; $display("FAIL full_etapa got %0d exp 7", etapa); end
  endtask

  task automatic test_wrong_move;
    start;
    play(7'h01); tick; tick;
    play(7'h02); tick; tick;
    play(7'h08);
    n_cmp++; if (db_estado !== 3'd5) begin n_bad++; $display("FAIL wrong_state got %0d exp 5", db_estado); end
    n_cmp++; if ({pronto, acertou, errou, timeout} !== 4'b1010) begin n_bad++; $display("FAIL wrong_flags got %b exp 1010", {pronto, acertou, errou, timeout}); end
    n_cmp++; if (etapa !== 3'd2) begin n_bad++; $display("FAIL wrong_etapa got %0d exp 2", etapa); end
  endtask

  task automatic test_bad_onehot;
    iniciar = 1'b1; jogada = 7'h01; jogada_valida = 1'b1; tick;
    iniciar = 1'b0;
    n_cmp++; if (db_estado !== 3'd1 || errou !== 1'b0) begin n_bad++; $display("FAIL err_restart got state %0d errou %b exp 1/0", db_estado, errou); end
    tick; jogada_valida = 1'b0; tick;
    n_cmp++; if (db_estado !== 3'd3 || etapa !== 3'd0) begin n_bad++; $display("FAIL ignore_strobe got state %0d etapa %0d exp 3/0", db_estado, etapa); end
    play(7'h00);
    n_cmp++; if (db_estado !== 3'd5 || errou !== 1'b1) begin n_bad++; $display("FAIL zero_move got state %0d errou %b exp 5/1", db_estado, errou); end
    play(7'h01);
    n_cmp++; if (db_estado !== 3'd5 || etapa !== 3'd0) begin n_bad++; $display("FAIL done_strobe got state %0d etapa %0d exp 5/0", db_estado, etapa); end
    start;
    play(7'h03);
    n_cmp++; if (db_estado !== 3'd5 || errou !== 1'b1 || acertou !== 1'b0) begin n_bad++; $display("FAIL multihot got state %0d errou %b acertou %b exp 5/1/0", db_estado, errou, acertou); end
  endtask

  task automatic test_restart_priority;
    start;
    test_full_recipe;
    iniciar = 1'b1; jogada = 7'h02; jogada_valida = 1'b1; tick;
    iniciar = 1'b0; jogada_valida = 1'b0;
    n_cmp++; if (db_estado !== 3'd1 || etapa !== 3'd0) begin n_bad++; $display("FAIL prio_state got state %0d etapa %0d exp 1/0", db_estado, etapa); end
    n_cmp++; if ({pronto, acertou, errou} !== 3'b000) begin n_bad++; $display("FAIL prio_flags got %b exp 000", {pronto, acertou, errou}); end
    tick; tick;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) begin
      play(rom_val(3'(i))); tick; tick;
    end
    n_cmp++; if (etapa !== 3'd4 || db_estado !== 3'd3) begin n_bad++; $display("FAIL mid_pre got etapa %0d state %0d exp 4/3", etapa, db_estado); end
    reset = 1'b1; tick; reset = 1'b0;
    n_cmp++; if (db_estado !== 3'd0 || etapa !== 3'd0 || rom_address !== 3'd0) begin n_bad++; $display("FAIL mid_rst got state %0d etapa %0d exp 0/0", db_estado, etapa); end
    n_cmp++; if ({pronto, acertou, errou, timeout} !== 4'b0) begin n_bad++; $display("FAIL mid_flags got %b exp 0000", {pronto, acertou, errou, timeout}); end
  endtask

  task automatic test_timeout;
    start;
`ifdef RECIPE_TIMEOUT_EN
    repeat (9) tick;
    n_cmp++; if (db_estado !== 3'd3) begin n_bad++; $display("FAIL to_early got %0d exp 3", db_estado); end
    tick;
    n_cmp++; if (db_estado !== 3'd5 || timeout !== 1'b1 || errou !== 1'b1) begin n_bad++; $display("FAIL to_fire got state %0d to %b errou %b exp 5/1/1", db_estado, timeout, errou); end
`else
    repeat (40) tick;
    n_cmp++; if (db_estado !== 3'd3 || timeout !== 1'b0) begin n_bad++; $display("FAIL no_timer got state %0d to %b exp 3/0", db_estado, timeout); end
`endif
    reset = 1'b1; tick; reset = 1'b0;
  endtask

  initial begin
    test_reset;
    test_full_recipe;
    test_wrong_move;
    test_bad_onehot;
    test_restart_priority;
    test_reset_mid;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
